game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level screen sequencer for SkyHop. It decides which screen owns the VGA chain: start screen, game, or end screen. It drives the enables for those stages and issues a one-cycle game restart pulse. On game over it captures the final score synchronously, maintains the session best score, and generates the blink enable for the end-screen "press spacebar" prompt.

## Interface
Parameters:
- FAIL_DELAY_SEC, default 1 — one_sec_tick count spent in FAIL before the end screen appears (range 1..15).
- END_LOCKOUT_SEC, default 2 — one_sec_tick count after END entry during which spacebar is ignored (range 0..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- space  in  1  spacebar level, already synchronised to clk.
- one_sec_tick  in  1  single-cycle pulse, once per second.
- jump_fail  in  1  single-cycle pulse from game logic: player missed a platform.
- score  in  12  live score, 3-digit BCD [11:8]=hundreds.
- start_en  out  1  start screen enable.
- game_en  out  1  game/physics enable.
- end_en  out  1  end-screen enable.
- blink_en  out  1  prompt visibility, qualified by end_en.
- game_rst  out  1  one-cycle pulse that clears game state and score.
- final_score  out  12  BCD score latched at game over.
- best_score  out  12  BCD session maximum.
- new_best  out  1  high while END is displayed if final_score beat best_score.

## Operation
- Press detect: press = space & ~space_q, where space_q is space delayed one clk. Only rising edges are acted on; holding space never repeats.
- FSM states: IDLE, PLAY, FAIL, END.
  - IDLE: start_en=1. On press, go to PLAY and pulse game_rst in the same transition cycle.
  - PLAY: game_en=1. On jump_fail, go to FAIL and load the delay counter with FAIL_DELAY_SEC. press is ignored.
  - FAIL: game_en=1 so the fall animation keeps running. On each one_sec_tick, decrement the counter. When a tick arrives with counter==1:
    - go to END;
    - final_score <= score;
    - if score > best_score (unsigned compare, valid for BCD), best_score <= score and new_best <= 1; otherwise new_best <= 0;
    - load the lockout counter with END_LOCKOUT_SEC.
  - END: end_en=1.
    - Each one_sec_tick toggles blink_en and decrements a nonzero lockout counter.
    - When the lockout counter is 0, press goes to PLAY, pulses game_rst, and clears new_best.
- Exactly one of start_en/game_en/end_en is 1 at any time.
- blink_en is 0 outside END and set to 1 on END entry.
- Input checks: score digits >9 are not checked. jump_fail outside PLAY is ignored.

## Timing
- All outputs are registered and update on the clk edge after the triggering input cycle (latency 1).
- Reset values:
  - state=IDLE, start_en=1, game_en=0, end_en=0;
  - blink_en=0, game_rst=0;
  - final_score=0, best_score=0, new_best=0;
  - counters=0, space_q=0.
- rst wins over every event in the same cycle. Reset mid-game returns to IDLE and clears best_score.
- Simultaneous events:
  - END, lockout==1, tick and press in the same cycle: the counter reaches 0, but the press is ignored. Lockout is evaluated on the pre-tick value.
  - jump_fail and press in the same PLAY cycle: go to FAIL.
- game_rst is high for exactly one cycle per PLAY entry, coincident with game_en rising.
- final_score is sampled from score in the cycle the FAIL→END tick is seen. It holds until the next FAIL→END transition.

## Test plan
- Reset, then hold space high 100 cycles → one game_rst pulse. game_en=1 from the cycle after the first edge, start_en=0, no further pulses.
- PLAY, score=12'h047, jump_fail, then 1 tick (FAIL_DELAY_SEC=1) → end_en=1, final_score=047, best_score=047, new_best=1, blink_en=1.
- In END, press before 2 ticks → ignored. After 2 ticks, press → PLAY with game_rst pulse and new_best=0. blink_en toggles 1→0→1 over those ticks.
- Second game ends with score=12'h039 → final_score=039, best_score stays 047, new_best=0. Third game with 12'h100 → best_score=100, new_best=1.
- Assert rst during FAIL and during END → IDLE next cycle, all outputs at reset values, best_score=0.
- In END with lockout==1, drive tick and press in the same cycle → remains in END. A press on the next cycle → PLAY.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// SkyHop screen sequencer: start screen -> game -> fall delay -> end screen,
// with restart pulse, final/best score capture and end-screen prompt blink.
module game_flow_ctrl #(
  parameter int unsigned FAIL_DELAY_SEC  = 1,
  parameter int unsigned END_LOCKOUT_SEC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        space,
  input  logic        one_sec_tick,
  input  logic        jump_fail,
  input  logic [11:0] score,
  output logic        start_en,
  output logic        game_en,
  output logic        end_en,
  output logic        blink_en,
  output logic        game_rst,
  output logic [11:0] final_score,
  output logic [11:0] best_score,
  output logic        new_best
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_FAIL = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        space_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        blink_q, blink_d;
  logic        game_rst_q, game_rst_d;
  logic [11:0] final_q, final_d;
  logic [11:0] best_q, best_d;
  logic        new_best_q, new_best_d;
  logic        press;

  assign press = space & ~space_q;

  // One counter serves both the fall delay (FAIL) and the spacebar lockout (END).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blink_d    = blink_q;
    game_rst_d = 1'b0;
    final_d    = final_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d    = S_PLAY;
          game_rst_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (jump_fail) begin
          state_d = S_FAIL;
          cnt_d   = 4'(FAIL_DELAY_SEC);
        end
      end
      S_FAIL: begin
        if (one_sec_tick) begin
          if (cnt_q == 4'd1) begin
            state_d = S_END;
            final_d = score;
            blink_d = 1'b1;
            cnt_d   = 4'(END_LOCKOUT_SEC);
            if (score > best_q) begin
              best_d     = score;
              new_best_d = 1'b1;
            end else begin
              new_best_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_END: begin
        if (one_sec_tick) begin
          blink_d = ~blink_q;
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        end
        // Lockout is judged on the pre-tick count, so a press riding the last tick is dropped.
        if (press && cnt_q == 4'd0) begin
          state_d    = S_PLAY;
          game_rst_d = 1'b1;
          new_best_d = 1'b0;
          blink_d    = 1'b0;
          cnt_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      space_q    <= 1'b0;
      cnt_q      <= '0;
      blink_q    <= 1'b0;
      game_rst_q <= 1'b0;
      final_q    <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      space_q    <= space;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      game_rst_q <= game_rst_d;
      final_q    <= final_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign start_en    = (state_q == S_IDLE);
  assign game_en     = (state_q == S_PLAY) || (state_q == S_FAIL);
  assign end_en      = (state_q == S_END);
  assign blink_en    = blink_q & end_en;
  assign game_rst    = game_rst_q;
  assign final_score = final_q;
  assign best_score  = best_q;
  assign new_best    = new_best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenario walk followed by random play,
// every cycle compared against a screen-level reference model.
module tb_game_flow_ctrl;

  localparam int unsigned FD = 1;
  localparam int unsigned EL = 2;

  logic        clk = 1'b0;
  logic        rst, space, one_sec_tick, jump_fail;
  logic [11:0] score;
  logic        start_en, game_en, end_en, blink_en, game_rst, new_best;
  logic [11:0] final_score, best_score;

  int n_assert = 0;
  int n_fail   = 0;

  game_flow_ctrl #(.FAIL_DELAY_SEC(FD), .END_LOCKOUT_SEC(EL)) dut (
    .clk(clk), .rst(rst), .space(space), .one_sec_tick(one_sec_tick),
    .jump_fail(jump_fail), .score(score), .start_en(start_en), .game_en(game_en),
    .end_en(end_en), .blink_en(blink_en), .game_rst(game_rst),
    .final_score(final_score), .best_score(best_score), .new_best(new_best)
  );

  always #5 clk = ~clk;

  // Reference model: which screen is showing and the bookkeeping around it.
  string       m_screen = "title";
  bit          m_space_prev = 0;
  int          m_fall_secs = 0;
  int          m_lock_secs = 0;
  bit          m_blink = 0;
  bit          m_restart = 0;
  int          m_final = 0;
  int          m_best = 0;
  bit          m_new_best = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clock(input bit sp, input bit tk, input bit jf, input int sc, input bit r);
    bit pressed;
    int lock_before;
    pressed = sp && !m_space_prev;
    m_space_prev = sp;
    m_restart = 0;
    if (r) begin
      m_screen = "title"; m_space_prev = 0; m_fall_secs = 0; m_lock_secs = 0;
      m_blink = 0; m_final = 0; m_best = 0; m_new_best = 0;
    end else if (m_screen == "title") begin
      if (pressed) begin m_screen = "play"; m_restart = 1; end
    end else if (m_screen == "play") begin
      if (jf) begin m_screen = "fall"; m_fall_secs = FD; end
    end else if (m_screen == "fall") begin
      if (tk) begin
        m_fall_secs--;
        if (m_fall_secs == 0) begin
          m_screen = "over";
          m_final = sc;
          m_new_best = (sc > m_best);
          if (sc > m_best) m_best = sc;
          m_lock_secs = EL;
          m_blink = 1;
        end
      end
    end else begin
      lock_before = m_lock_secs;
      if (tk) begin
        m_blink = !m_blink;
        if (m_lock_secs > 0) m_lock_secs--;
      end
      if (pressed && lock_before == 0) begin
        m_screen = "play"; m_restart = 1; m_new_best = 0; m_blink = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("start_en", 12'(start_en), 12'(m_screen == "title"));
    chk("game_en",  12'(game_en),  12'(m_screen == "play" || m_screen == "fall"));
    chk("end_en",   12'(end_en),   12'(m_screen == "over"));
    chk("blink_en", 12'(blink_en), 12'(m_blink && m_screen == "over"));
    chk("game_rst", 12'(game_rst), 12'(m_restart));
    chk("final_score", final_score, 12'(m_final));
    chk("best_score",  best_score,  12'(m_best));
    chk("new_best", 12'(new_best), 12'(m_new_best));
  endtask

  task automatic step(input bit sp, input bit tk, input bit jf, input int sc, input bit r);
    space = sp; one_sec_tick = tk; jump_fail = jf; score = 12'(sc); rst = r;
    @(posedge clk);
    model_clock(sp, tk, jf, sc, r);
    #1;
    compare_all();
  endtask

  function automatic int rand_bcd();
    return (int'($urandom_range(9)) << 8) | (int'($urandom_range(9)) << 4) | int'($urandom_range(9));
  endfunction

  initial begin
    int rst_pulses;
    rst = 1'b1; space = 1'b0; one_sec_tick = 1'b0; jump_fail = 1'b0; score = '0;
    #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_start_en", 12'(start_en), 12'd1);

    // Hold space: exactly one restart pulse.
    rst_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 0, 0);
      if (game_rst) rst_pulses++;
    end
    chk("hold_space_pulses", 12'(rst_pulses), 12'd1);
    chk("hold_space_game_en", 12'(game_en), 12'd1);
    step(0, 0, 0, 'h047, 0);

    // First game over at 047.
    step(1, 0, 1, 'h047, 0);
    step(0, 1, 0, 'h047, 0);
    chk("g1_end_en", 12'(end_en), 12'd1);
    chk("g1_final", final_score, 12'h047);
    chk("g1_best", best_score, 12'h047);
    chk("g1_new_best", 12'(new_best), 12'd1);
    chk("g1_blink", 12'(blink_en), 12'd1);

    // Early press ignored, then two ticks unlock.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("locked_press", 12'(end_en), 12'd1);
    step(0, 1, 0, 0, 0);
    chk("blink_after_tick1", 12'(blink_en), 12'd0);
    step(0, 1, 0, 0, 0);
    chk("blink_after_tick2", 12'(blink_en), 12'd1);
    step(1, 0, 0, 0, 0);
    chk("restart_pulse", 12'(game_rst), 12'd1);
    chk("restart_new_best", 12'(new_best), 12'd0);

    // Second game at 039: best holds.
    step(0, 0, 1, 'h039, 0);
    step(0, 1, 0, 'h039, 0);
    chk("g2_final", final_score, 12'h039);
    chk("g2_best", best_score, 12'h047);
    chk("g2_new_best", 12'(new_best), 12'd0);

    // Tick and press together with lockout at 1: press dropped.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("tick_press_stay", 12'(end_en), 12'd1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("late_press_play", 12'(game_en), 12'd1);

    // Third game at 100: new best.
    step(0, 0, 1, 'h100, 0);
    step(0, 1, 0, 'h100, 0);
    chk("g3_best", best_score, 12'h100);
    chk("g3_new_best", 12'(new_best), 12'd1);

    // Reset during END, then during FAIL.
    step(0, 0, 0, 0, 1);
    chk("rst_end_best", best_score, 12'h000);
    chk("rst_end_start", 12'(start_en), 12'd1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 'h222, 0);
    step(0, 0, 0, 'h222, 1);
    chk("rst_fail_start", 12'(start_en), 12'd1);
    chk("rst_fail_final", final_score, 12'h000);

    // Random play.
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(15) == 0), ($urandom_range(19) == 0),
           rand_bcd(), ($urandom_range(799) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
